mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single data memory port between the instruction-fetch stage and the MEM stage of the pipelined processor. Each access runs through a three-state sequence of arbitrate, access, and respond. The block returns read data and a one-cycle acknowledge to the winning requester, and drives the memory address, write-data and write-enable lines. Data accesses have priority. An optional starvation guard bounds how long fetch can be held off.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `STARVE_MAX`, default 4: number of consecutive data wins over a pending fetch before fetch is forced; must be ≥1.
- `clk`, in, 1: the only clock, rising edge.
- `reset`, in, 1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `if_req`, in, 1: fetch read request; held until `if_ack`.
- `if_addr`, in, AW: fetch byte address.
- `if_ack`, out, 1: one-cycle pulse; `if_rdata` is valid in the same cycle.
- `if_rdata`, out, DW: fetched word.
- `d_req`, in, 1: data request; held until `d_ack`.
- `d_we`, in, 1: 1 = store, 0 = load.
- `d_addr`, in, AW: data byte address.
- `d_wdata`, in, DW: store data.
- `d_ack`, out, 1: one-cycle pulse; `d_rdata` is valid in the same cycle (it holds the read-back value for stores).
- `d_rdata`, out, DW: loaded word.
- `mem_addr`, out, AW: memory address, registered.
- `mem_wdata`, out, DW: memory write data, registered.
- `mem_we`, out, 1: memory write enable; high only in ACCESS for a store.
- `mem_rdata`, in, DW: combinational read data from the memory.
- `busy`, out, 1: high in ACCESS and RESP.
- `owner`, out, 1: current or last grant; 0 = fetch, 1 = data.

## Operation
- States are IDLE, ACCESS and RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: select a winner, latch its address, write data and `we` into `mem_addr`, `mem_wdata` and an internal we register, set `owner`, then go to ACCESS.
  - Fetch requests always latch we=0.
- **Winner selection**
  - If `d_req` is high, data wins.
  - Otherwise fetch wins.
  - With the guard compiled in, see Configuration.
- **ACCESS**
  - `mem_we` equals the latched we.
  - At the end of the cycle, sample `mem_rdata` into the winner's rdata register.
  - Go to RESP.
- **RESP**
  - Pulse the winner's ack for one cycle; the other ack stays 0.
  - `mem_we` is 0.
  - Go to IDLE.
- **Requester handshake**
  - The requester may drop `req` at the edge that ends RESP.
  - If `req` is still high in the next IDLE cycle, it is treated as a new request.
  - Changing the address or data while `req` is high and no ack has arrived is illegal.
- **Registers outside a grant**
  - `if_rdata` and `d_rdata` hold their last value.
  - `mem_addr` and `mem_wdata` hold their last value.
- **Address bits** are passed through unmodified. Word indexing (`[5:2]`) is done by the memory, not by this block.

## Timing
- Request first seen in IDLE at cycle N → ACCESS at N+1 → ack at N+2. Next IDLE is N+3.
- Peak throughput is one access per 3 cycles.
- `mem_we` is decoded only from the state register and the latched we, so it never depends on inputs combinationally.
- Simultaneous `if_req` and `d_req` in IDLE: one grant only. The loser keeps `req` high and is arbitrated again in the next IDLE.
- Reset values: state IDLE; `if_ack`, `d_ack`, `mem_we`, `busy` and `owner` are 0; `if_rdata`, `d_rdata`, `mem_addr` and `mem_wdata` are 0; starvation counter is 0.
- Reset low during ACCESS or RESP aborts the access and no ack is issued.
- Because `mem_we` was high in ACCESS, a store aborted by reset in ACCESS may already have been written; this is accepted.
- Reset low while a request is held: after reset is released, the first IDLE cycle arbitrates normally.

## Configuration
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- **Defined:** a counter `starve_cnt`, 0..STARVE_MAX, is evaluated at each IDLE arbitration.
  - Data wins while fetch is pending: increment, saturating at STARVE_MAX.
  - Fetch wins, or `if_req` is low: clear to 0.
  - Both request and `starve_cnt==STARVE_MAX`: fetch wins.
- **Undefined:** strict data priority. The counter and its logic are not present.

## Structure
- Package `mem_arb_pkg`:
  - State enum `arb_state_t` {IDLE, ACCESS, RESP}.
  - Owner constants `OWN_IF=1'b0` and `OWN_D=1'b1`.
  - `STARVE_MAX_DEF=4`.
- Sub-module `arb_starve_guard` holds the saturating counter and produces the force-fetch output. It is instantiated only under the macro.

## Test plan
- **Lone fetch:** `if_req=1`, `if_addr=0x8`, `mem_rdata=36` → `if_ack` in the third cycle with `if_rdata=36`; `mem_we` stays 0 throughout.
- **Lone store:** `d_req=1`, `d_we=1`, `d_addr=0x10`, `d_wdata=77` → `mem_we=1` for exactly one cycle with `mem_addr=0x10` and `mem_wdata=77`; `d_ack` the next cycle.
- **Simultaneous requests:** both requests in one IDLE cycle → `d_ack` at +2 and `if_ack` at +5; `owner` goes 1 then 0.
- **Starvation guard (macro defined, STARVE_MAX=4):** `if_req` and `d_req` both held high continuously → 4 data grants, then 1 fetch grant; the pattern repeats.
- **Strict priority (macro undefined):** same stimulus as the starvation test → `if_ack` never pulses.
- **Reset during access:** `reset=0` asserted during ACCESS → no ack; all outputs at reset values after the edge; the held request is granted again and acked 3 cycles after reset is released.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

  // Arbitration sequence: pick a winner, drive the memory, return the ack.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Grant owner encoding.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Default number of consecutive data wins before a pending fetch is forced.
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_starve_guard.sv
// Starvation guard: counts consecutive data wins over a pending fetch and
// raises force_fetch once the count reaches STARVE_MAX.
module arb_starve_guard
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,       // synchronous, active-low
  input  logic arb_en,      // an arbitration happens this cycle
  input  logic if_pending,  // fetch is requesting this cycle
  input  logic data_win,    // data wins this arbitration
  output logic force_fetch
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_reg;

  // Saturating count of data wins that held off a pending fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt_reg <= '0;
    end else if (arb_en) begin
      if (data_win && if_pending) begin
        if (starve_cnt_reg != CNT_MAX) begin
          starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
      end else begin
        starve_cnt_reg <= '0;
      end
    end
  end

  assign force_fetch = (starve_cnt_reg == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single data-memory port shared by instruction fetch and the
// MEM stage. Each grant runs IDLE -> ACCESS -> RESP; data has priority.
// Optional starvation guard is compiled in with MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,      // synchronous, active-low
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_t state_reg;
  arb_state_t state_next;
  logic       we_reg;
  logic       arb_en;
  logic       data_win;
  logic       force_fetch;

  // An arbitration happens in any IDLE cycle that sees a request.
  assign arb_en = (state_reg == IDLE) && (if_req || d_req);

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_guard #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_guard (
    .clk        (clk),
    .reset      (reset),
    .arb_en     (arb_en),
    .if_pending (if_req),
    .data_win   (data_win),
    .force_fetch(force_fetch)
  );
`else
  // Strict data priority: fetch is never forced.
  assign force_fetch = 1'b0;
`endif

  // Data wins unless the guard forces a pending fetch through.
  assign data_win = d_req && !(force_fetch && if_req);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: every grant takes exactly three cycles.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (if_req || d_req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant capture in IDLE and read-data capture at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_reg    <= 1'b0;
      owner     <= OWN_IF;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (arb_en) begin
        if (data_win) begin
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          we_reg    <= d_we;
          owner     <= OWN_D;
        end else begin
          // Fetch is read-only; write data is left untouched.
          mem_addr  <= if_addr;
          we_reg    <= 1'b0;
          owner     <= OWN_IF;
        end
      end
      if (state_reg == ACCESS) begin
        if (owner == OWN_D) begin
          d_rdata <= mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

  // Outputs decoded from registers only, so nothing depends on inputs.
  assign mem_we = (state_reg == ACCESS) && we_reg;
  assign busy   = (state_reg != IDLE);
  assign if_ack = (state_reg == RESP) && (owner == OWN_IF);
  assign d_ack  = (state_reg == RESP) && (owner == OWN_D);

endmodule
